// File: rtl/pat_scan_pkg.sv
// Shared definitions for the pattern-buffer scan path.
// Holds the default frame geometry, the buffer-index width, the readback
// latency seen through the receiver (two synchroniser flops plus the chain
// output register), and the scan master's FSM state type.
package pat_scan_pkg;

    localparam int FRAME_BYTES_DEF = 22;
    localparam int BYTE_W_DEF      = 8;
    localparam int ADDR_W          = 3;
    localparam int SYNC_DEPTH      = 2;
    localparam int RB_LAT_DEF      = SYNC_DEPTH + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } scan_state_e;

endpackage

// File: rtl/scan_rb_capture.sv
// Readback capture for the scan master.
// A delay line tracks ssel so that sout is sampled exactly in the cycles
// where the displaced counterpart of a driven bit arrives. Samples are
// deserialised MSB first into bytes.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   ssel        shift enable as driven to the receiver
//   sout        serial readback from the receiver
//   rb_byte     last completed readback byte
//   rb_valid    one-cycle strobe when rb_byte updates
//   pending     high while any shifted bit has not yet been sampled
module scan_rb_capture
    import pat_scan_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int LAT    = RB_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ssel,
    input  logic              sout,
    output logic [BYTE_W-1:0] rb_byte,
    output logic              rb_valid,
    output logic              pending
);

    localparam int IDX_W = $clog2(BYTE_W);

    logic [LAT-1:0]    dly_r;
    logic [BYTE_W-2:0] sh_r;
    logic [IDX_W-1:0]  idx_r;
    logic [BYTE_W-1:0] rb_byte_r;
    logic              rb_valid_r;
    logic              sample_s;

    // The oldest delay-line stage marks a cycle where sout carries a displaced bit.
    assign sample_s = dly_r[LAT-1];

    // Delay line, deserialiser and byte strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_r      <= {LAT{1'b0}};
            sh_r       <= {(BYTE_W-1){1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            rb_byte_r  <= {BYTE_W{1'b0}};
            rb_valid_r <= 1'b0;
        end else begin
            dly_r      <= {dly_r[LAT-2:0], ssel};
            rb_valid_r <= 1'b0;
            if (sample_s) begin
                sh_r <= {sh_r[BYTE_W-3:0], sout};
                if (idx_r == IDX_W'(BYTE_W-1)) begin
                    idx_r      <= {IDX_W{1'b0}};
                    rb_byte_r  <= {sh_r, sout};
                    rb_valid_r <= 1'b1;
                end else begin
                    idx_r <= idx_r + 1'b1;
                end
            end
        end
    end

    assign rb_byte  = rb_byte_r;
    assign rb_valid = rb_valid_r;
    assign pending  = |dly_r;

endmodule

// File: rtl/scan_loader.sv
// Serial-scan master for the pattern buffer test port.
// Loads one FRAME_BYTES image per start command, MSB first, one bit per clk
// while ssel is high, stalling (ssel low, sin held) whenever the host has no
// byte ready. The displaced chain contents come back on sout and are
// returned as rb_byte/rb_valid. done pulses while busy is still high, so a
// start in that cycle is ignored.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   start, start_addr     command strobe and target buffer index
//   busy, done            frame in progress / end-of-frame pulse
//   byte_in, byte_valid,
//   byte_ready            host byte stream (accepted on valid && ready)
//   rb_byte, rb_valid     readback bytes
//   sin, ssel, saddr      scan port to the pattern buffer
//   sout                  serial readback from the pattern buffer
module scan_loader
    import pat_scan_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int BYTE_W      = BYTE_W_DEF,
    parameter int SETUP_CYC   = 3,
    parameter int HOLD_CYC    = 3,
    parameter int RB_LAT      = RB_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [BYTE_W-1:0] rb_byte,
    output logic              rb_valid,
    output logic              sin,
    output logic              ssel,
    output logic [ADDR_W-1:0] saddr,
    input  logic              sout
);

    localparam int TOTAL_BITS = FRAME_BYTES * BYTE_W;
    localparam int BIT_CNT_W  = $clog2(TOTAL_BITS + 1);
    localparam int BYTE_CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int IDX_W      = $clog2(BYTE_W);
    localparam int PH_MAX     = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int PH_W       = $clog2(PH_MAX + 1);

    scan_state_e         state_r, state_nxt;
    logic [ADDR_W-1:0]   saddr_r, saddr_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;
    logic                byte_ready_r, byte_ready_nxt;
    logic                sin_r, sin_nxt;
    logic                ssel_r, ssel_nxt;
    logic [BYTE_W-2:0]   sh_r, sh_nxt;          // bits of the current byte not yet driven
    logic [IDX_W-1:0]    bits_left_r, bits_left_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt_r, bit_cnt_nxt;
    logic [BYTE_CNT_W-1:0] byte_cnt_r, byte_cnt_nxt;
    logic [PH_W-1:0]     ph_cnt_r, ph_cnt_nxt;  // shared by SETUP and HOLD
    logic                accept_s;
    logic                rb_pending_s;

    assign accept_s = byte_valid && byte_ready_r;

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_nxt     = state_r;
        saddr_nxt     = saddr_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        sin_nxt       = sin_r;
        ssel_nxt      = 1'b0;
        sh_nxt        = sh_r;
        bits_left_nxt = bits_left_r;
        bit_cnt_nxt   = bit_cnt_r;
        byte_cnt_nxt  = byte_cnt_r;
        ph_cnt_nxt    = ph_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt     = ST_SETUP;
                    saddr_nxt     = start_addr;
                    busy_nxt      = 1'b1;
                    bits_left_nxt = {IDX_W{1'b0}};
                    bit_cnt_nxt   = {BIT_CNT_W{1'b0}};
                    byte_cnt_nxt  = {BYTE_CNT_W{1'b0}};
                    ph_cnt_nxt    = {PH_W{1'b0}};
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (ph_cnt_r == PH_W'(SETUP_CYC - 1)) begin
                    state_nxt  = ST_SHIFT;
                    ph_cnt_nxt = {PH_W{1'b0}};
                end else begin
                    ph_cnt_nxt = ph_cnt_r + 1'b1;
                end
            end
            ST_SHIFT: begin
                // The terminal count is only ever reached, never passed.
                if (bit_cnt_r == BIT_CNT_W'(TOTAL_BITS)) begin
                    state_nxt = ST_HOLD;
                end else if (bits_left_r != {IDX_W{1'b0}}) begin
                    sin_nxt       = sh_r[BYTE_W-2];
                    sh_nxt        = {sh_r[BYTE_W-3:0], 1'b0};
                    bits_left_nxt = bits_left_r - 1'b1;
                    ssel_nxt      = 1'b1;
                    bit_cnt_nxt   = bit_cnt_r + 1'b1;
                end else if (accept_s) begin
                    sin_nxt       = byte_in[BYTE_W-1];
                    sh_nxt        = byte_in[BYTE_W-2:0];
                    bits_left_nxt = IDX_W'(BYTE_W - 1);
                    byte_cnt_nxt  = byte_cnt_r + 1'b1;
                    ssel_nxt      = 1'b1;
                    bit_cnt_nxt   = bit_cnt_r + 1'b1;
                end else begin
                    // Underrun: no shift this cycle, sin keeps its value.
                    ssel_nxt = 1'b0;
                end
            end
            ST_HOLD: begin
                if (ph_cnt_r == PH_W'(HOLD_CYC - 1)) begin
                    state_nxt  = ST_DRAIN;
                    ph_cnt_nxt = {PH_W{1'b0}};
                end else begin
                    ph_cnt_nxt = ph_cnt_r + 1'b1;
                end
            end
            ST_DRAIN: begin
                // done is raised while still busy; busy drops the cycle after.
                if (done_r) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else if (!rb_pending_s) begin
                    done_nxt = 1'b1;
                end else begin
                    done_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Ready is registered, so it is derived from the state being entered.
        byte_ready_nxt = (state_nxt == ST_SHIFT) &&
                         (bits_left_nxt == {IDX_W{1'b0}}) &&
                         (byte_cnt_nxt < BYTE_CNT_W'(FRAME_BYTES));
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            saddr_r      <= {ADDR_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            byte_ready_r <= 1'b0;
            sin_r        <= 1'b0;
            ssel_r       <= 1'b0;
            sh_r         <= {(BYTE_W-1){1'b0}};
            bits_left_r  <= {IDX_W{1'b0}};
            bit_cnt_r    <= {BIT_CNT_W{1'b0}};
            byte_cnt_r   <= {BYTE_CNT_W{1'b0}};
            ph_cnt_r     <= {PH_W{1'b0}};
        end else begin
            state_r      <= state_nxt;
            saddr_r      <= saddr_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
            byte_ready_r <= byte_ready_nxt;
            sin_r        <= sin_nxt;
            ssel_r       <= ssel_nxt;
            sh_r         <= sh_nxt;
            bits_left_r  <= bits_left_nxt;
            bit_cnt_r    <= bit_cnt_nxt;
            byte_cnt_r   <= byte_cnt_nxt;
            ph_cnt_r     <= ph_cnt_nxt;
        end
    end

    scan_rb_capture #(
        .BYTE_W (BYTE_W),
        .LAT    (RB_LAT)
    ) u_rb_capture (
        .clk      (clk),
        .rst_n    (rst_n),
        .ssel     (ssel_r),
        .sout     (sout),
        .rb_byte  (rb_byte),
        .rb_valid (rb_valid),
        .pending  (rb_pending_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign byte_ready = byte_ready_r;
    assign sin        = sin_r;
    assign ssel       = ssel_r;
    assign saddr      = saddr_r;

endmodule

// File: tb/tb_scan_loader.sv
// Self-checking bench for scan_loader.
// The pattern buffer is modelled as 2-flop synchronisers on sin/ssel/saddr
// feeding eight 176-bit chains with a registered output. Expected readback
// is predicted at byte level: each buffer returns the image it last held.
`timescale 1ns/1ps
module tb_scan_loader;

    localparam int FB        = 22;
    localparam int BW        = 8;
    localparam int NBITS     = FB * BW;
    localparam int SETUP_CYC = 3;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       start      = 1'b0;
    logic [2:0] start_addr = 3'd0;
    logic       busy;
    logic       done;
    logic [7:0] byte_in    = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [7:0] rb_byte;
    logic       rb_valid;
    logic       sin;
    logic       ssel;
    logic [2:0] saddr;
    logic       sout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_model [8][FB];   // image each buffer currently holds
    logic [7:0] tx [FB];             // bytes for the next frame
    logic       preload = 1'b1;

    always #5 clk = ~clk;

    scan_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .rb_byte    (rb_byte),
        .rb_valid   (rb_valid),
        .sin        (sin),
        .ssel       (ssel),
        .saddr      (saddr),
        .sout       (sout)
    );

    // Pattern buffer receiver model.
    logic [NBITS-1:0] chain [8];
    logic       sin_q1 = 1'b0, sin_q2 = 1'b0;
    logic       ssel_q1 = 1'b0, ssel_q2 = 1'b0;
    logic [2:0] addr_q1 = 3'd0, addr_q2 = 3'd0;
    logic       sout_m = 1'b0;

    always @(posedge clk) begin
        sin_q1  <= sin;   sin_q2  <= sin_q1;
        ssel_q1 <= ssel;  ssel_q2 <= ssel_q1;
        addr_q1 <= saddr; addr_q2 <= addr_q1;
        if (preload) begin
            for (int a = 0; a < 8; a++)
                for (int k = 0; k < FB; k++)
                    chain[a][NBITS-1-8*k -: 8] <= mem_model[a][k];
        end else if (ssel_q2) begin
            sout_m         <= chain[addr_q2][NBITS-1];
            chain[addr_q2] <= {chain[addr_q2][NBITS-2:0], sin_q2};
        end
    end
    assign sout = sout_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from tx[] to addr; optional stall, start-while-busy and abort.
    task automatic run_frame(input logic [2:0] addr, input int stall_at, input int stall_len,
                             input int inj_at, input int abort_at);
        logic [7:0] got [FB];
        logic [7:0] rbq [$];
        int sent, nbits, first, last, cyc, setup_cnt, addr_bad, done_cnt, rb_at_done;
        int stall_left, extra_done;
        bit fin, done_seen, inj_done, aborted;
        sent = 0; nbits = 0; first = -1; last = -1; cyc = 0; setup_cnt = 0;
        addr_bad = 0; done_cnt = 0; rb_at_done = -1; stall_left = stall_len;
        extra_done = 0; fin = 0; done_seen = 0; inj_done = 0; aborted = 0;
        for (int k = 0; k < FB; k++) got[k] = 8'd0;

        @(negedge clk);
        start = 1'b1;
        start_addr = addr;
        while (!fin && !aborted && cyc < 3000) begin
            @(negedge clk);
            start = 1'b0;
            start_addr = 3'($urandom_range(0, 7));
            cyc++;
            // observe
            if (done_seen) begin
                chk("busy_falls", busy, 1'b0);
                fin = 1;
            end
            if (ssel === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (nbits < NBITS) got[nbits / 8][7 - (nbits % 8)] = sin;
                nbits++;
                if (saddr !== addr) addr_bad++;
            end else if (first < 0 && saddr === addr) begin
                setup_cnt++;
            end
            if (rb_valid === 1'b1) rbq.push_back(rb_byte);
            if (done === 1'b1) begin
                done_cnt++;
                rb_at_done = rbq.size();
                done_seen = 1;
            end
            // abort by asynchronous reset
            if (abort_at >= 0 && nbits >= abort_at) begin
                rst_n = 1'b0;
                byte_valid = 1'b0;
                #1;
                chk("abort_ssel", ssel, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_sin", sin, 1'b0);
                chk("abort_saddr", saddr, 3'd0);
                chk("abort_ready", byte_ready, 1'b0);
                chk("abort_rbvalid", rb_valid, 1'b0);
                chk("abort_rbbyte", rb_byte, 8'd0);
                aborted = 1;
            end else begin
                // drive host stream
                if (inj_at >= 0 && !inj_done && nbits >= inj_at) begin
                    start = 1'b1;
                    start_addr = 3'd2;
                    inj_done = 1;
                end
                if (sent < FB) begin
                    if (sent == stall_at && stall_left > 0) begin
                        byte_valid = 1'b0;
                        if (byte_ready === 1'b1) stall_left--;
                    end else begin
                        byte_valid = 1'b1;
                        byte_in = tx[sent];
                        if (byte_ready === 1'b1) sent++;
                    end
                end else begin
                    byte_valid = 1'b0;
                end
            end
        end

        if (aborted) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done !== 1'b0) extra_done++;
            end
            chk("abort_no_done", extra_done, 0);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            chk("abort_idle_ssel", ssel, 1'b0);
        end else begin
            chk("frame_timeout", fin, 1'b1);
            chk("setup_cycles_ok", setup_cnt >= SETUP_CYC, 1'b1);
            chk("ssel_bits", nbits, NBITS);
            chk("ssel_gap", (last - first + 1) - nbits, stall_len);
            chk("saddr_during_shift", addr_bad, 0);
            for (int k = 0; k < FB; k++) chk("sin_byte", got[k], tx[k]);
            chk("done_count", done_cnt, 1);
            chk("rb_before_done", rb_at_done, FB);
            chk("rb_count", rbq.size(), FB);
            for (int k = 0; k < FB; k++)
                chk("rb_byte", (k < rbq.size()) ? rbq[k] : 8'hxx, mem_model[addr][k]);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done !== 1'b0) extra_done++;
            end
            chk("no_extra_done", extra_done, 0);
            chk("saddr_kept", saddr, addr);
            for (int k = 0; k < FB; k++) mem_model[addr][k] = tx[k];
        end
    endtask

    initial begin
        int hi_cnt;
        for (int a = 0; a < 8; a++)
            for (int k = 0; k < FB; k++)
                mem_model[a][k] = (a == 5) ? 8'hA5 : 8'($urandom);

        // asynchronous reset, applied between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sin", sin, 1'b0);
        chk("rst_ssel", ssel, 1'b0);
        chk("rst_saddr", saddr, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_rbvalid", rb_valid, 1'b0);
        chk("rst_rbbyte", rb_byte, 8'd0);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ssel !== 1'b0 || busy !== 1'b0) hi_cnt++;
        end
        chk("idle_quiet", hi_cnt, 0);

        // frame 1: 0x00..0x15 to buffer 5, continuous stream, readback 0xA5
        for (int k = 0; k < FB; k++) tx[k] = 8'(k);
        run_frame(3'd5, -1, 0, -1, -1);

        // frame 2: random bytes, 7-cycle underrun after byte 3, start while busy
        for (int k = 0; k < FB; k++) tx[k] = 8'($urandom);
        run_frame(3'd5, 4, 7, 60, -1);

        // frame 3: abandoned by reset after 40 bits
        for (int k = 0; k < FB; k++) tx[k] = 8'($urandom);
        run_frame(3'd5, -1, 0, -1, 40);

        // frame 4: full frame to buffer 1 with a random underrun
        for (int k = 0; k < FB; k++) tx[k] = 8'($urandom);
        run_frame(3'd1, $urandom_range(1, 20), $urandom_range(1, 12), -1, -1);

        // frame 5: buffer 1 again, returns frame 4 image
        for (int k = 0; k < FB; k++) tx[k] = 8'($urandom);
        run_frame(3'd1, $urandom_range(1, 20), $urandom_range(0, 5), -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_loader.md
Name: scan_loader

Overview:
- Serial-scan master that drives the pattern buffer's test port (sin, ssel, saddr) from a parallel host byte stream.
- Loads one complete buffer image (FRAME_BYTES bytes) per command.
- Captures the displaced chain contents from sout and returns them as readback bytes.
- Sits between the host/config interface and patternbuffer, in the same clk domain. The receiver's 2-flop synchronisers add a fixed delay that this block compensates for.

Parameters:
- FRAME_BYTES, 22, bytes per buffer image (buffer_size).
- BYTE_W, 8, bits per byte (buffer_width).
- SETUP_CYC, 3, cycles saddr is held with ssel low before the first shift (covers the receiver's 2-flop sync).
- HOLD_CYC, 3, cycles saddr is held after ssel falls.
- RB_LAT, 3, cycles from a sin bit being driven to its displaced counterpart appearing on sout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe, accepted only in IDLE
- start_addr  in  3  target buffer index, latched on an accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of frame
- byte_in  in  BYTE_W  next byte to shift
- byte_valid  in  1  byte_in valid
- byte_ready  out  1  byte accepted when valid && ready
- rb_byte  out  BYTE_W  readback byte
- rb_valid  out  1  one-cycle strobe, no backpressure
- sin  out  1  serial data to patternbuffer
- ssel  out  1  shift enable: exactly one bit shifts per clk while high
- saddr  out  3  buffer select
- sout  in  1  serial readback from patternbuffer

Behaviour:
- Reset (async, rst_n low): state IDLE; sin=0, ssel=0, saddr=0, busy=0, done=0, byte_ready=0, rb_valid=0, rb_byte=0. Internal counters and ssel delay line cleared.
- FSM states are IDLE, SETUP, SHIFT, HOLD, DRAIN.
- IDLE:
  - start=1 latches start_addr into saddr, sets busy, clears the bit and byte counters, and moves to SETUP.
  - start while busy is ignored.
- SETUP:
  - ssel=0, saddr stable.
  - After SETUP_CYC cycles, go to SHIFT.
- SHIFT:
  - byte_ready=1 only when the shift register is empty.
  - Bytes shift MSB first, one bit per cycle, with ssel=1 in each cycle a bit is driven.
  - A byte is accepted in the cycle valid&&ready; its MSB appears on sin with ssel=1 in the next cycle, so there are no bubbles when byte_valid is continuously high.
  - Underrun (shift register empty and no valid byte): ssel=0 and sin holds its value; the frame stalls without limit. Stalls never corrupt bit order.
  - After FRAME_BYTES*BYTE_W bits (176 by default), go to HOLD.
- HOLD:
  - ssel=0; go to DRAIN after HOLD_CYC cycles.
- DRAIN:
  - Wait until the ssel delay line is empty, then pulse done, clear busy, return to IDLE.
  - saddr keeps its value in IDLE.
- Readback:
  - A delay line of depth RB_LAT carries the ssel value.
  - When its output is 1, sout is sampled into the readback shift register, MSB first.
  - Every BYTE_W samples, rb_byte is updated and rb_valid pulses for one cycle.
  - Exactly FRAME_BYTES rb_valid pulses occur per frame, all before done.
  - Stalls propagate through the delay line, so readback alignment is stall-independent.
- Widths:
  - Bit counter: $clog2(FRAME_BYTES*BYTE_W+1) bits.
  - Byte bit index: $clog2(BYTE_W) bits.
  - The counter saturates at the terminal count; no wrap is permitted.
- Simultaneous events:
  - done and a new start in the same cycle: start is ignored, because busy is still high in that cycle.
  - byte_valid in IDLE/SETUP is ignored (byte_ready=0).
- Reset mid-frame: all outputs return to reset values immediately; the partial frame is abandoned. The receiver sees ssel=0, so its chain is left partially shifted; the host must reload.

Decomposition:
- Shared package (pat_scan_pkg):
  - FRAME_BYTES and BYTE_W defaults.
  - Buffer-index width (3).
  - Readback latency constant RB_LAT = sync depth 2 + 1 chain register.
  - FSM state enum.
- Sub-module scan_rb_capture: ssel delay line plus sout deserialiser producing rb_byte/rb_valid. The rest stays in scan_loader.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously, busy=0. Release; 10 idle cycles -> ssel stays 0.
- Full frame: start with start_addr=5, bytes 0x00..0x15 streamed with byte_valid=1 continuously:
  - saddr=5 for SETUP_CYC cycles with ssel=0.
  - Then ssel=1 for exactly 176 contiguous cycles; sin sequence equals the bytes MSB first.
  - done pulses once; busy then falls.
- Readback loopback: model patternbuffer as 2-flop sync + 176-bit chain preloaded with 0xA5 in every byte -> 22 rb_valid pulses, each rb_byte=0xA5. A second frame returns 0x00..0x15.
- Underrun: withhold byte_valid for 7 cycles after byte 3 -> ssel=0 for exactly those 7 cycles, total ssel-high cycles still 176, readback still matches byte-for-byte.
- Start while busy: pulse start with start_addr=2 during SHIFT -> ignored; saddr remains 5 and the frame completes normally.
- Reset mid-shift: drop rst_n after bit 40 -> ssel=0 and busy=0 immediately, no done pulse. A subsequent full frame to address 1 completes correctly.
